// File: rtl/reflet_float_to_int_arbiter.sv
// Round-robin arbiter that time-shares a single float-to-signed-integer converter
// among nb_req requesters, with registered operand/result and a valid/ready result port.

module reflet_float_to_int_arbiter #(
    parameter int float_size = 32,
    parameter int int_size   = 16,
    parameter int nb_req     = 4,
    parameter int id_size    = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [nb_req-1:0]              req_valid,
    input  logic [nb_req*float_size-1:0]   req_float,
    output logic [nb_req-1:0]              req_ready,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [int_size-1:0]            res_int,
    output logic [id_size-1:0]             res_id,
    output logic                           busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CONVERT = 2'd1;
    localparam logic [1:0] RESPOND = 2'd2;

    localparam int exp_w  = (float_size == 64) ? 11 : ((float_size == 16) ? 5 : 8);
    localparam int man_w  = float_size - exp_w - 1;
    localparam int bias   = (1 << (exp_w - 1)) - 1;
    localparam int mag_w  = int_size - 1;
    localparam int wide_w = man_w + int_size + 1;

    // Truncating conversion: integer part of the float, with exponent -1 rounding up to 1
    // and a saturated magnitude once the value reaches 2^int_size.
    function automatic logic [int_size-1:0] float_to_int(input logic [float_size-1:0] f);
        logic              sign;
        logic [exp_w-1:0]  exp_field;
        logic [man_w-1:0]  man_field;
        logic [wide_w-1:0] full;
        logic [mag_w-1:0]  mag;
        logic [mag_w-1:0]  twos;
        int                e;
        sign      = f[float_size-1];
        exp_field = f[float_size-2 -: exp_w];
        man_field = f[man_w-1:0];
        e         = int'(exp_field) - bias;
        full      = wide_w'({1'b1, man_field});
        if (e >= int_size) begin
            mag = '1;
        end else if (e >= man_w) begin
            mag = mag_w'(full << (e - man_w));
        end else if (e >= 0) begin
            mag = mag_w'(full >> (man_w - e));
        end else if (e == -1) begin
            mag = mag_w'(1);
        end else begin
            mag = '0;
        end
        if (sign) begin
            twos = ~mag + mag_w'(1);
        end else begin
            twos = mag;
        end
        return {sign, twos};
    endfunction

    logic [1:0]            state_q, state_d;
    logic [float_size-1:0] op_q, op_d;
    logic [id_size-1:0]    id_q, id_d;
    logic [id_size-1:0]    ptr_q, ptr_d;
    logic                  res_valid_q, res_valid_d;
    logic [int_size-1:0]   res_int_q, res_int_d;
    logic [id_size-1:0]    res_id_q, res_id_d;
    logic                  busy_q, busy_d;

    logic                  found_s;
    logic [id_size-1:0]    gnt_idx_s;
    logic                  grant_en_s;
    logic                  grant_s;
    logic [nb_req-1:0]     req_ready_s;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        int idx;
        found_s   = 1'b0;
        gnt_idx_s = '0;
        idx       = 0;
        for (int k = 1; k <= nb_req; k++) begin
            idx = (int'(ptr_q) + k) % nb_req;
            if (!found_s && req_valid[idx]) begin
                found_s   = 1'b1;
                gnt_idx_s = id_size'(idx);
            end else begin
                found_s   = found_s;
            end
        end
    end

    // Grants are offered only when the converter pipeline can take a new operand.
    always_comb begin
        grant_en_s  = (state_q == IDLE) || ((state_q == RESPOND) && res_ready);
        grant_s     = grant_en_s && found_s;
        req_ready_s = '0;
        if (grant_s) begin
            req_ready_s[gnt_idx_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
    end

    assign req_ready = req_ready_s;

    // Next-state and datapath for the IDLE / CONVERT / RESPOND sequence.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        id_d        = id_q;
        ptr_d       = ptr_q;
        res_valid_d = res_valid_q;
        res_int_d   = res_int_q;
        res_id_d    = res_id_q;
        if (grant_s) begin
            op_d  = req_float[gnt_idx_s*float_size +: float_size];
            id_d  = gnt_idx_s;
            ptr_d = gnt_idx_s;
        end else begin
            op_d  = op_q;
        end
        case (state_q)
            IDLE: begin
                if (grant_s) begin
                    state_d = CONVERT;
                end else begin
                    state_d = IDLE;
                end
            end
            CONVERT: begin
                res_int_d   = float_to_int(op_q);
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                state_d     = RESPOND;
            end
            RESPOND: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (grant_s) begin
                        state_d = CONVERT;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = RESPOND;
                end
            end
            default: begin
                state_d     = IDLE;
                res_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset drops any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            id_q        <= '0;
            ptr_q       <= id_size'(nb_req - 1);
            res_valid_q <= 1'b0;
            res_int_q   <= '0;
            res_id_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            id_q        <= id_d;
            ptr_q       <= ptr_d;
            res_valid_q <= res_valid_d;
            res_int_q   <= res_int_d;
            res_id_q    <= res_id_d;
            busy_q      <= busy_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_int   = res_int_q;
    assign res_id    = res_id_q;
    assign busy      = busy_q;

    reflet_float_to_int_arbiter_chk #(
        .int_size (int_size),
        .nb_req   (nb_req),
        .id_size  (id_size)
    ) u_chk (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_int   (res_int),
        .res_id    (res_id)
    );

endmodule

// Protocol checker for the arbiter's grant and result handshakes.
module reflet_float_to_int_arbiter_chk #(
    parameter int int_size = 16,
    parameter int nb_req   = 4,
    parameter int id_size  = 2
) (
    input logic                clk,
    input logic                reset,
    input logic [nb_req-1:0]   req_valid,
    input logic [nb_req-1:0]   req_ready,
    input logic                res_valid,
    input logic                res_ready,
    input logic [int_size-1:0] res_int,
    input logic [id_size-1:0]  res_id
);

    a_grant_onehot : assert property (@(posedge clk) disable iff (!reset)
        $onehot0(req_ready));

    a_grant_valid : assert property (@(posedge clk) disable iff (!reset)
        ((req_ready & ~req_valid) == '0));

    a_result_hold : assert property (@(posedge clk) disable iff (!reset)
        (res_valid && !res_ready) |=> (res_valid && $stable(res_int) && $stable(res_id)));

endmodule

// File: tb/tb_reflet_float_to_int_arbiter.sv
// Scoreboard bench for the shared float-to-int converter arbiter (32-bit float, 16-bit int, 4 requesters).

module tb_reflet_float_to_int_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [127:0] req_float;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_int;
    logic [1:0]  res_id;
    logic        busy;

    reflet_float_to_int_arbiter #(
        .float_size (32),
        .int_size   (16),
        .nb_req     (4),
        .id_size    (2)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .req_valid (req_valid),
        .req_float (req_float),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_int   (res_int),
        .res_id    (res_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] val;
    } exp_t;

    typedef struct {
        int id;
        int cyc;
    } gnt_t;

    exp_t        exp_q[$];
    gnt_t        gnt_log[$];
    logic [15:0] cur_exp[4];
    logic [3:0]  hold;
    logic [3:0]  granted_q;
    int          cyc;
    int          n_checks;
    int          n_errors;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
        end
    endtask

    // Scoreboard monitor: push expectations on grants, compare on result handshakes.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            granted_q = 4'b0000;
        end else begin
            granted_q = req_valid & req_ready;
            if (granted_q != 4'b0000) begin
                exp_t e;
                gnt_t g;
                int   idx;
                idx = 0;
                for (int i = 0; i < 4; i++) if (granted_q[i]) idx = i;
                check_eq("grant_onehot", 32'($countones(granted_q)), 32'd1);
                e.id  = idx;
                e.val = cur_exp[idx];
                g.id  = idx;
                g.cyc = cyc;
                gnt_log.push_back(g);
                exp_q.push_back(e);
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_result", 32'(res_int), 32'hDEAD_BEEF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("res_int", 32'(res_int), 32'(e.val));
                    check_eq("res_id", 32'(res_id), 32'(e.id));
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (granted_q[i] && !hold[i]) req_valid[i] = 1'b0;
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] f, input logic [15:0] e);
        req_float[i*32 +: 32] = f;
        cur_exp[i]            = e;
        req_valid[i]          = 1'b1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        hold      = 4'b0000;
        res_ready = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b1;
        gnt_log.delete();
        cycle();
    endtask

    task automatic wait_grants(input int n);
        int budget;
        budget = 0;
        while (gnt_log.size() < n && budget < 60) begin
            cycle();
            budget++;
        end
        if (gnt_log.size() < n) check_eq("grant_timeout", 32'(gnt_log.size()), 32'(n));
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((exp_q.size() != 0 || req_valid != 4'b0000) && budget < 80) begin
            cycle();
            budget++;
        end
        if (exp_q.size() != 0) check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int base;
        int found_at;
        n_checks  = 0;
        n_errors  = 0;
        cyc       = 0;
        granted_q = 4'b0000;
        hold      = 4'b0000;
        req_valid = 4'b0000;
        req_float = '0;
        res_ready = 1'b0;
        rst_n     = 1'b0;
        for (int i = 0; i < 4; i++) cur_exp[i] = 16'h0000;
        do_reset();

        // Reset state
        @(negedge clk);
        check_eq("rst_res_valid", 32'(res_valid), 32'd0);
        check_eq("rst_res_int", 32'(res_int), 32'd0);
        check_eq("rst_res_id", 32'(res_id), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);

        // Test 1: single request, latency
        cycle();
        set_req(0, 32'h3F80_0000, 16'h0001);
        @(negedge clk);
        check_eq("t1_req_ready", 32'(req_ready), 32'h1);
        cycle();
        @(negedge clk);
        check_eq("t1_lat1_valid", 32'(res_valid), 32'd0);
        check_eq("t1_busy", 32'(busy), 32'd1);
        cycle();
        @(negedge clk);
        check_eq("t1_lat2_valid", 32'(res_valid), 32'd1);
        res_ready = 1'b1;
        drain();

        // Test 2: four requesters, round-robin order and throughput
        do_reset();
        res_ready = 1'b1;
        set_req(0, 32'h40A0_0000, 16'h0005);
        set_req(1, 32'hC000_0000, 16'hFFFE);
        set_req(2, 32'h3E80_0000, 16'h0000);
        set_req(3, 32'h4974_2400, 16'h7FFF);
        wait_grants(4);
        if (gnt_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check_eq("t2_order", 32'(gnt_log[i].id), 32'(i));
                if (i > 0) check_eq("t2_spacing", 32'(gnt_log[i].cyc - gnt_log[i-1].cyc), 32'd2);
            end
        end
        drain();

        // Test 3: backpressure with a pending request
        res_ready = 1'b0;
        set_req(2, 32'h447A_0000, 16'h03E8);
        base = 0;
        while (!res_valid && base < 20) begin
            cycle();
            base++;
        end
        check_eq("t3_valid_seen", 32'(res_valid), 32'd1);
        set_req(0, 32'hC2F6_0000, 16'hFF85);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("t3_hold_valid", 32'(res_valid), 32'd1);
            check_eq("t3_hold_int", 32'(res_int), 32'h03E8);
            check_eq("t3_hold_id", 32'(res_id), 32'd2);
            check_eq("t3_no_grant", 32'(req_ready), 32'd0);
            check_eq("t3_busy", 32'(busy), 32'd1);
            cycle();
        end
        res_ready = 1'b1;
        @(negedge clk);
        check_eq("t3_same_cycle_grant", 32'(req_ready), 32'h1);
        drain();

        // Test 4: fairness between two held requesters, then a late one
        gnt_log.delete();
        hold = 4'b1010;
        set_req(1, 32'h3F00_0000, 16'h0001);
        set_req(3, 32'hBF80_0000, 16'hFFFF);
        wait_grants(4);
        if (gnt_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) check_eq("t4_alternate", 32'(gnt_log[i].id), (i % 2 == 0) ? 32'd1 : 32'd3);
        end
        base = gnt_log.size();
        set_req(0, 32'h0000_0000, 16'h0000);
        found_at = -1;
        for (int k = 0; k < 40 && found_at < 0; k++) begin
            cycle();
            for (int j = base; j < gnt_log.size(); j++) begin
                if (found_at < 0 && gnt_log[j].id == 0) found_at = j - base + 1;
            end
        end
        check_eq("t4_fair_found", 32'(found_at > 0 && found_at <= 4), 32'd1);
        hold      = 4'b0000;
        req_valid = 4'b0000;
        drain();

        // Test 5: reset during CONVERT
        gnt_log.delete();
        set_req(2, 32'h3E80_0000, 16'h0000);
        base = 0;
        while (req_ready == 4'b0000 && base < 20) begin
            @(negedge clk);
            base++;
        end
        cycle();
        rst_n = 1'b0;
        #1;
        check_eq("t5_async_valid", 32'(res_valid), 32'd0);
        check_eq("t5_async_busy", 32'(busy), 32'd0);
        req_valid = 4'b0000;
        repeat (2) cycle();
        rst_n = 1'b1;
        gnt_log.delete();
        set_req(0, 32'h40A0_0000, 16'h0005);
        set_req(1, 32'hC000_0000, 16'hFFFE);
        set_req(2, 32'h3E80_0000, 16'h0000);
        set_req(3, 32'h4974_2400, 16'h7FFF);
        @(negedge clk);
        check_eq("t5_first_grant", 32'(req_ready), 32'h1);
        check_eq("t5_no_stale", 32'(res_valid), 32'd0);
        wait_grants(4);
        if (gnt_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) check_eq("t5_order", 32'(gnt_log[i].id), 32'(i));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
